ladybird_debug_bridge: RTL and testbench
========================================

LADYBIRD_DEBUG_BRIDGE -- requirements
Module: ladybird_debug_bridge

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning bus address/data width; only 32 is supported.
REQ-002 SHALL have parameter TIMEOUT, default 16'hFFFF, meaning idle cycles allowed between command bytes before abort.
REQ-003 SHALL use one clock and a synchronous, active-high reset (clk, rst).
REQ-004 Ports (name  direction  width  meaning):
 clk  in  1  clock
 rst  in  1  synchronous reset, active-high
 rx_valid  in  1  received byte strobe from the serial receiver, one cycle per byte
 rx_data  in  8  received byte
 tx_valid  out  1  reply byte offered to the serial transmitter
 tx_ready  in  1  transmitter accepts tx_data when tx_valid and tx_ready are both high
 tx_data  out  8  reply byte
 bus_valid  out  1  bus request, initiator side
 bus_ready  in  1  responder accepts the request
 bus_we  out  1  1 = write, 0 = read
 bus_addr  out  32  byte address
 bus_wdata  out  32  write data
 bus_wstrb  out  4  byte enables; 4'hF on writes, 4'h0 on reads
 bus_rvalid  in  1  read data valid
 bus_rdata  in  32  read data
 busy  out  1  high in any state other than IDLE
 overrun  out  1  sticky flag: a byte arrived while it could not be consumed

Function
REQ-005 Command 0x57 ('W') + 4 address bytes + 4 data bytes, all little-endian, SHALL issue one bus write and then reply 0x4B ('K').
REQ-006 Command 0x52 ('R') + 4 address bytes SHALL issue one bus read and reply with the 4 rdata bytes, LSB first.
REQ-007 Any other byte in IDLE SHALL produce a reply of 0x3F ('?') and return to IDLE.
REQ-008 States: IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, REPLY.
 IDLE->ADDR on 'W' or 'R'.
 ADDR->DATA after the 4th address byte when the command is 'W'; ADDR->BUS_REQ after the 4th byte when it is 'R'.
 DATA->BUS_REQ after the 4th data byte.
 BUS_REQ->REPLY on a write handshake; BUS_REQ->BUS_WAIT on a read handshake.
 BUS_WAIT->REPLY on bus_rvalid.
 REPLY->IDLE when the last reply byte is accepted.
REQ-009 A 2-bit byte counter SHALL index the address and data bytes, resetting to 0 on each state entry.
REQ-010 bus_valid SHALL assert the cycle after BUS_REQ is entered; bus_addr, bus_we, bus_wdata and bus_wstrb SHALL remain stable until bus_ready is seen high; bus_valid SHALL deassert the cycle after the handshake.
REQ-011 bus_rvalid SHALL be ignored until the cycle after the read handshake; bus_rdata SHALL be captured on the first bus_rvalid.
REQ-012 tx_valid SHALL stay high with tx_data stable until tx_ready; the next reply byte SHALL be offered no earlier than the cycle after acceptance.
REQ-013 In ADDR or DATA, if TIMEOUT consecutive cycles pass without rx_valid, the bridge SHALL return to IDLE silently, with no bus access and no reply.
REQ-014 rx_valid in BUS_REQ, BUS_WAIT or REPLY SHALL drop the byte and set overrun; overrun SHALL clear only on rst.
REQ-015 There SHALL be no bus timeout; BUS_REQ and BUS_WAIT SHALL wait indefinitely.
REQ-016 Address bits SHALL pass unmodified; unaligned addresses SHALL be forwarded as-is.

Reset
REQ-017 On rst the state SHALL be IDLE, the counters 0, and tx_valid, bus_valid, bus_we, busy and overrun all 0; bus_addr, bus_wdata, bus_wstrb and tx_data SHALL be 0.
REQ-018 rst asserted mid-transaction SHALL abandon the transaction in the same edge, with no further bus or tx activity.

Structure
REQ-019 The command and reply byte constants (0x57, 0x52, 0x4B, 0x3F) and the state enum typedef SHALL live in package ladybird_config alongside XLEN.
REQ-020 Reply serialisation SHALL be a sub-module, ladybird_debug_reply: it loads 1 or 4 bytes and shifts them out over tx_valid/tx_ready.

Verification
REQ-021 Bytes 57 00 00 00 90 EF BE AD DE with bus_ready tied high -> one write with addr 0x9000_0000, wdata 0xDEAD_BEEF, wstrb 4'hF, then tx byte 0x4B.
REQ-022 Bytes 52 10 00 00 90 with rdata 0x1234_5678 returned 3 cycles after accept -> tx bytes 78 56 34 12 in order.
REQ-023 Byte 0x41 -> tx byte 0x3F, no bus_valid, state back to IDLE.
REQ-024 Bytes 57 00 00, then silence for TIMEOUT+1 cycles -> no bus_valid, busy falls, and a following 'R' command works normally.
REQ-025 bus_ready held low for 20 cycles with rx_valid pulsed during the wait -> bus_addr stable throughout, overrun=1, single transaction completes.
REQ-026 rst asserted while in BUS_WAIT -> next cycle bus_valid=0, tx_valid=0, busy=0, overrun=0.

Source files
------------

// File: rtl/ladybird_debug_bridge_pkg.sv
// Shared constants and types for the ladybird debug bridge:
// the command/reply byte codes, the bus width and the FSM state encoding.
package ladybird_config;

  localparam int unsigned XLEN = 32;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR   = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_DATA     = 3'd2,
    ST_BUS_REQ  = 3'd3,
    ST_BUS_WAIT = 3'd4,
    ST_REPLY    = 3'd5
  } state_t;

  function automatic logic is_command(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/ladybird_debug_reply.sv
// Reply serialiser: loads 1..4 bytes and offers them LSB first over a
// valid/ready byte channel, holding each byte stable until accepted.
module ladybird_debug_reply (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [2:0]  len_i,
  input  logic [31:0] bytes_i,
  input  logic        tx_ready_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  output logic        last_o
);

  logic [23:0] shift_q;
  logic [2:0]  left_q;
  logic        valid_q;
  logic [7:0]  data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      data_q  <= bytes_i[7:0];
      shift_q <= bytes_i[31:8];
      left_q  <= len_i;
      valid_q <= 1'b1;
    end else if (valid_q && tx_ready_i) begin
      if (left_q == 3'd1) begin
        valid_q <= 1'b0;
        left_q  <= '0;
      end else begin
        // Next byte is presented in the cycle following acceptance.
        data_q  <= shift_q[7:0];
        shift_q <= {8'h00, shift_q[23:8]};
        left_q  <= left_q - 3'd1;
      end
    end
  end

  assign tx_valid_o = valid_q;
  assign tx_data_o  = data_q;
  assign last_o     = valid_q && tx_ready_i && (left_q == 3'd1);

endmodule

// File: rtl/ladybird_debug_bridge.sv
// Byte-stream debug bridge: parses 'W'/'R' commands from a serial receiver,
// performs one bus access per command and serialises the reply bytes.
module ladybird_debug_bridge #(
  parameter int unsigned XLEN    = 32,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic [7:0]      tx_data,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            busy,
  output logic            overrun
);

  import ladybird_config::*;

  state_t          state_q;
  logic [1:0]      cnt_q;
  logic [15:0]     idle_q;
  logic            is_write_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            bus_valid_q;
  logic            bus_we_q;
  logic [XLEN-1:0] bus_addr_q;
  logic [XLEN-1:0] bus_wdata_q;
  logic [3:0]      bus_wstrb_q;
  logic            overrun_q;

  logic            reply_load_d;
  logic [2:0]      reply_len_d;
  logic [31:0]     reply_bytes_d;
  logic            reply_last;

  // Reply loads coincide with the FSM edges that enter REPLY.
  always_comb begin
    reply_load_d  = 1'b0;
    reply_len_d   = 3'd1;
    reply_bytes_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && !is_command(rx_data)) begin
          reply_load_d  = 1'b1;
          reply_bytes_d = {24'h0, RSP_ERR};
        end
      end
      ST_BUS_REQ: begin
        if (bus_valid_q && bus_ready && bus_we_q) begin
          reply_load_d  = 1'b1;
          reply_bytes_d = {24'h0, RSP_OK};
        end
      end
      ST_BUS_WAIT: begin
        if (bus_rvalid) begin
          reply_load_d  = 1'b1;
          reply_len_d   = 3'd4;
          reply_bytes_d = bus_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idle_q      <= '0;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (rx_valid && (state_q == ST_BUS_REQ || state_q == ST_BUS_WAIT ||
                       state_q == ST_REPLY)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            if (is_command(rx_data)) begin
              is_write_q <= (rx_data == CMD_WRITE);
              cnt_q      <= '0;
              idle_q     <= '0;
              state_q    <= ST_ADDR;
            end else begin
              state_q <= ST_REPLY;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          if (rx_valid) begin
            idle_q <= '0;
            cnt_q  <= cnt_q + 2'd1;
            if (state_q == ST_ADDR) begin
              addr_q[{cnt_q, 3'b000} +: 8] <= rx_data;
            end else begin
              wdata_q[{cnt_q, 3'b000} +: 8] <= rx_data;
            end
            if (cnt_q == 2'd3) begin
              if (state_q == ST_ADDR && is_write_q) begin
                state_q <= ST_DATA;
              end else begin
                // Bus fields are frozen here and held through the handshake.
                state_q     <= ST_BUS_REQ;
                bus_we_q    <= is_write_q;
                bus_wstrb_q <= is_write_q ? 4'hF : 4'h0;
                bus_addr_q  <= (state_q == ST_ADDR) ? {rx_data, addr_q[23:0]} : addr_q;
                bus_wdata_q <= (state_q == ST_DATA) ? {rx_data, wdata_q[23:0]} : '0;
              end
            end
          end else if (idle_q == TIMEOUT - 16'd1) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idle_q  <= '0;
          end else begin
            idle_q <= idle_q + 16'd1;
          end
        end
        ST_BUS_REQ: begin
          if (!bus_valid_q) begin
            bus_valid_q <= 1'b1;
          end else if (bus_ready) begin
            bus_valid_q <= 1'b0;
            state_q     <= bus_we_q ? ST_REPLY : ST_BUS_WAIT;
          end
        end
        ST_BUS_WAIT: begin
          if (bus_rvalid) begin
            state_q <= ST_REPLY;
          end
        end
        ST_REPLY: begin
          if (reply_last) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ladybird_debug_reply u_reply (
    .clk        (clk),
    .rst        (rst),
    .load_i     (reply_load_d),
    .len_i      (reply_len_d),
    .bytes_i    (reply_bytes_d),
    .tx_ready_i (tx_ready),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data),
    .last_o     (reply_last)
  );

  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ladybird_debug_bridge.sv
// Bench for the debug bridge: directed scenarios plus random commands, with
// a command-level reference model, a bus responder and a tx byte collector.
module tb_ladybird_debug_bridge;

  localparam logic [15:0] TMO = 16'd24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  ladybird_debug_bridge #(.XLEN(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .busy(busy), .overrun(overrun)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  bus_t        obs_bus[$];
  bus_t        exp_bus[$];
  logic [7:0]  obs_tx[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  cmd_q[$];
  logic [31:0] slave_mem[logic [31:0]];
  logic [31:0] model_mem[logic [31:0]];

  int n_assert = 0;
  int n_fail = 0;
  int ready_delay = 0;
  int rv_delay = 1;
  bit ready_tied = 1'b0;
  int tx_ready_pct = 100;
  int stab_err = 0;
  int proto_err = 0;
  int tx_err = 0;

  // Bus responder: memory where unwritten locations read as ~addr. Drives junk
  // rvalid during the read handshake cycle, which the bridge must ignore.
  initial begin
    bus_t req;
    logic [31:0] rd;
    int wait_n;
    bus_ready = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !bus_valid) begin
        bus_ready = ready_tied;
        continue;
      end
      req.we = bus_we;
      req.addr = bus_addr;
      req.wdata = bus_wdata;
      req.wstrb = bus_wstrb;
      wait_n = 0;
      while (wait_n < ready_delay) begin
        bus_ready = 1'b0;
        @(negedge clk);
        wait_n++;
        if ({bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb} !==
            {1'b1, req.we, req.addr, req.wdata, req.wstrb}) stab_err++;
      end
      rd = slave_mem.exists(req.addr) ? slave_mem[req.addr] : ~req.addr;
      bus_ready = 1'b1;
      bus_rvalid = !req.we;
      bus_rdata = rd ^ 32'h5A5A_5A5A;
      obs_bus.push_back(req);
      if (req.we) slave_mem[req.addr] = req.wdata;
      @(negedge clk);
      bus_rvalid = 1'b0;
      bus_rdata = '0;
      bus_ready = ready_tied;
      if (bus_valid !== 1'b0) proto_err++;
      if (!req.we) begin
        repeat (rv_delay - 1) @(negedge clk);
        bus_rvalid = 1'b1;
        bus_rdata = rd;
        @(negedge clk);
        bus_rvalid = 1'b0;
        bus_rdata = '0;
      end
    end
  end

  // Tx collector with random backpressure and a hold-stable check.
  initial begin
    logic pend;
    logic [7:0] pend_data;
    pend = 1'b0;
    pend_data = '0;
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
        tx_ready = 1'b0;
        continue;
      end
      if (pend && (tx_valid !== 1'b1 || tx_data !== pend_data)) tx_err++;
      tx_ready = ($urandom_range(99) < tx_ready_pct);
      if (tx_valid === 1'b1) begin
        if (tx_ready) begin
          obs_tx.push_back(tx_data);
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          pend_data = tx_data;
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic set_cmd_w(input logic [31:0] a, input logic [31:0] d);
    cmd_q.delete();
    cmd_q.push_back(8'h57);
    for (int k = 0; k < 4; k++) cmd_q.push_back(a[8*k +: 8]);
    for (int k = 0; k < 4; k++) cmd_q.push_back(d[8*k +: 8]);
  endtask

  task automatic set_cmd_r(input logic [31:0] a);
    cmd_q.delete();
    cmd_q.push_back(8'h52);
    for (int k = 0; k < 4; k++) cmd_q.push_back(a[8*k +: 8]);
  endtask

  // Reference model: command semantics straight from the byte protocol.
  task automatic model_cmd();
    logic [31:0] a;
    logic [31:0] d;
    bus_t e;
    exp_bus.delete();
    exp_tx.delete();
    obs_bus.delete();
    obs_tx.delete();
    a = '0;
    if (cmd_q.size() >= 5) a = {cmd_q[4], cmd_q[3], cmd_q[2], cmd_q[1]};
    if (cmd_q[0] == 8'h57) begin
      d = {cmd_q[8], cmd_q[7], cmd_q[6], cmd_q[5]};
      e.we = 1'b1; e.addr = a; e.wdata = d; e.wstrb = 4'hF;
      exp_bus.push_back(e);
      model_mem[a] = d;
      exp_tx.push_back(8'h4B);
    end else if (cmd_q[0] == 8'h52) begin
      e.we = 1'b0; e.addr = a; e.wdata = '0; e.wstrb = 4'h0;
      exp_bus.push_back(e);
      d = model_mem.exists(a) ? model_mem[a] : ~a;
      for (int k = 0; k < 4; k++) exp_tx.push_back(d[8*k +: 8]);
    end else begin
      exp_tx.push_back(8'h3F);
    end
  endtask

  task automatic send_cmd(input int max_gap);
    foreach (cmd_q[i]) begin
      send_byte(cmd_q[i]);
      repeat ($urandom_range(max_gap)) @(negedge clk);
    end
  endtask

  task automatic finish_cmd(input string tag);
    int cyc;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".idle"}, {31'b0, busy}, 32'd0);
    check({tag, ".nbus"}, obs_bus.size(), exp_bus.size());
    for (int i = 0; i < obs_bus.size() && i < exp_bus.size(); i++) begin
      check({tag, ".we"}, {31'b0, obs_bus[i].we}, {31'b0, exp_bus[i].we});
      check({tag, ".addr"}, obs_bus[i].addr, exp_bus[i].addr);
      check({tag, ".wstrb"}, {28'b0, obs_bus[i].wstrb}, {28'b0, exp_bus[i].wstrb});
      if (exp_bus[i].we) check({tag, ".wdata"}, obs_bus[i].wdata, exp_bus[i].wdata);
    end
    check({tag, ".ntx"}, obs_tx.size(), exp_tx.size());
    for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++) begin
      check($sformatf("%s.tx%0d", tag, i), {24'b0, obs_tx[i]}, {24'b0, exp_tx[i]});
    end
    $display("txn %s: bus=%0d tx=%0d", tag, obs_bus.size(), obs_tx.size());
  endtask

  task automatic run_cmd(input string tag, input int max_gap);
    model_cmd();
    send_cmd(max_gap);
    finish_cmd(tag);
  endtask

  logic [31:0] addr_pool[6];

  initial begin
    int cyc;
    int kind;
    logic [7:0] junk;
    logic [31:0] a;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst.bus_valid", {31'b0, bus_valid}, 32'd0);
    check("rst.bus_we", {31'b0, bus_we}, 32'd0);
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.overrun", {31'b0, overrun}, 32'd0);
    check("rst.bus_addr", bus_addr, 32'd0);
    check("rst.bus_wdata", bus_wdata, 32'd0);
    check("rst.bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
    check("rst.tx_data", {24'b0, tx_data}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write with bus_ready tied high
    ready_tied = 1'b1;
    tx_ready_pct = 100;
    set_cmd_w(32'h9000_0000, 32'hDEAD_BEEF);
    run_cmd("write_tied", 0);
    ready_tied = 1'b0;

    // Read returning data three cycles after the handshake
    set_cmd_w(32'h9000_0010, 32'h1234_5678);
    run_cmd("write_pre", 1);
    rv_delay = 3;
    set_cmd_r(32'h9000_0010);
    run_cmd("read_3cyc", 0);

    // Unknown command byte
    cmd_q.delete();
    cmd_q.push_back(8'h41);
    run_cmd("unknown", 0);

    // Timeout mid-address, then a normal read
    obs_bus.delete();
    obs_tx.delete();
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (TMO - 2) @(negedge clk);
    check("tmo.busy_before", {31'b0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    check("tmo.busy_after", {31'b0, busy}, 32'd0);
    check("tmo.nbus", obs_bus.size(), 32'd0);
    check("tmo.ntx", obs_tx.size(), 32'd0);
    rv_delay = 2;
    set_cmd_r(32'h9000_0000);
    run_cmd("tmo_read", 1);

    // Bus stall with a byte arriving during the wait
    check("ovr.before", {31'b0, overrun}, 32'd0);
    ready_delay = 20;
    stab_err = 0;
    set_cmd_w(32'h0000_0102, 32'hA5A5_0F0F);
    model_cmd();
    send_cmd(0);
    repeat (5) @(negedge clk);
    send_byte(8'h41);
    finish_cmd("stall");
    check("stall.overrun", {31'b0, overrun}, 32'd1);
    check("stall.addr_stable", stab_err, 32'd0);
    ready_delay = 0;

    // Reset while waiting for read data
    rv_delay = 10;
    set_cmd_r(32'h9000_0010);
    model_cmd();
    send_cmd(0);
    cyc = 0;
    while (obs_bus.size() == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rstw.handshake", obs_bus.size(), 32'd1);
    repeat (2) @(negedge clk);
    check("rstw.busy_before", {31'b0, busy}, 32'd1);
    check("rstw.overrun_sticky", {31'b0, overrun}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstw.bus_valid", {31'b0, bus_valid}, 32'd0);
    check("rstw.tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rstw.busy", {31'b0, busy}, 32'd0);
    check("rstw.overrun", {31'b0, overrun}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rstw.no_tx", obs_tx.size(), 32'd0);
    check("rstw.idle", {31'b0, busy}, 32'd0);
    $display("txn rst_in_wait: tx=%0d", obs_tx.size());

    // Random command mix
    addr_pool[0] = 32'h0000_0003;
    addr_pool[1] = 32'hFFFF_FFFD;
    addr_pool[2] = 32'h9000_0010;
    addr_pool[3] = $urandom;
    addr_pool[4] = $urandom;
    addr_pool[5] = 32'h8000_0001;
    for (int it = 0; it < 30; it++) begin
      ready_delay = $urandom_range(3);
      rv_delay = $urandom_range(4, 1);
      tx_ready_pct = $urandom_range(100, 40);
      kind = $urandom_range(4);
      a = addr_pool[$urandom_range(5)];
      if (kind <= 1) begin
        set_cmd_w(a, $urandom);
      end else if (kind <= 3) begin
        set_cmd_r(a);
      end else begin
        junk = 8'($urandom);
        if (junk == 8'h57 || junk == 8'h52) junk = 8'hAA;
        cmd_q.delete();
        cmd_q.push_back(junk);
      end
      run_cmd($sformatf("rand%0d", it), 3);
    end

    check("end.overrun", {31'b0, overrun}, 32'd0);
    check("end.bus_stable", stab_err, 32'd0);
    check("end.bus_valid_drop", proto_err, 32'd0);
    check("end.tx_stable", tx_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
